// File: rtl/mem_init_seq.sv
// mem_init_seq: memory init / clear / pattern-fill sequencer.
// Sweeps an inclusive, possibly wrapping address range and drives one write
// per address into the data bundle of the downstream 2:1 memory-port mux.
// It also drives the mux select for the whole sweep. All outputs are registered.
module mem_init_seq #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic              sel_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_INCR  = 2'd1;
    localparam logic [1:0] MODE_XOR   = 2'd2;

    // FSM state and sweep parameters captured at start
    state_t              state_reg,   state_next;
    logic [1:0]          mode_reg,    mode_next;
    logic [DATA_W-1:0]   fill_reg,    fill_next;
    logic [ADDR_W-1:0]   end_reg,     end_next;
    // Number of accepted writes in this sweep, modulo 2**DATA_W
    logic [DATA_W-1:0]   offset_reg,  offset_next;

    // Registered output bundle
    logic [ADDR_W-1:0]   addr_reg,    addr_next;
    logic [DATA_W-1:0]   data_reg,    data_next;
    logic                wr_en_reg,   wr_en_next;
    logic                sel_reg,     sel_next;
    logic                busy_reg,    busy_next;
    logic                done_reg,    done_next;

    // Pattern generator operands: the address/offset the data will belong to
    logic [1:0]          pat_mode;
    logic [DATA_W-1:0]   pat_fill;
    logic [ADDR_W-1:0]   pat_addr;
    logic [DATA_W-1:0]   pat_offset;
    logic [DATA_W-1:0]   pat_data;

    // Per-bit helper vectors for the address-derived patterns
    logic [DATA_W-1:0]   xor_bits;
    logic [DATA_W-1:0]   checker_bits;

    // Incremented address and offset used on every accepted write
    logic [ADDR_W-1:0]   addr_inc;
    logic [DATA_W-1:0]   offset_inc;
    logic                accept;
    logic                last_write;

    assign addr_inc   = addr_reg + ADDR_W'(1);
    assign offset_inc = offset_reg + DATA_W'(1);
    assign accept     = wr_en_reg && !stall;
    assign last_write = (addr_reg == end_reg);

    // Address-derived pattern bits. Data bits above the address width (only
    // possible with a narrow ADDR_W) see an address bit of zero.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pat_bits
            if (gi < ADDR_W) begin : g_addr_bit
                assign xor_bits[gi] = pat_fill[gi] ^ pat_addr[gi];
            end else begin : g_no_addr_bit
                assign xor_bits[gi] = pat_fill[gi];
            end
            // Checker: odd addresses get the inverted seed
            assign checker_bits[gi] = pat_fill[gi] ^ pat_addr[0];
        end
    endgenerate

    // Select the write data for the address/offset currently on the pattern bus
    always_comb begin
        pat_data = pat_fill;
        case (pat_mode)
            MODE_CONST: pat_data = pat_fill;
            MODE_INCR:  pat_data = pat_fill + pat_offset;
            MODE_XOR:   pat_data = xor_bits;
            default:    pat_data = checker_bits;
        endcase
    end

    // Next-state and next-output logic; abort takes priority over acceptance
    always_comb begin
        state_next  = state_reg;
        mode_next   = mode_reg;
        fill_next   = fill_reg;
        end_next    = end_reg;
        offset_next = offset_reg;
        addr_next   = addr_reg;
        data_next   = data_reg;
        wr_en_next  = wr_en_reg;
        sel_next    = sel_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;

        // By default the pattern bus looks one write ahead in the running sweep
        pat_mode    = mode_reg;
        pat_fill    = fill_reg;
        pat_addr    = addr_inc;
        pat_offset  = offset_inc;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    // Capture the sweep and present the first write next cycle;
                    // its data is generated from the live inputs.
                    pat_mode    = mode;
                    pat_fill    = fill_value;
                    pat_addr    = start_addr;
                    pat_offset  = '0;
                    state_next  = ST_RUN;
                    mode_next   = mode;
                    fill_next   = fill_value;
                    end_next    = end_addr;
                    offset_next = '0;
                    addr_next   = start_addr;
                    data_next   = pat_data;
                    wr_en_next  = 1'b1;
                    sel_next    = 1'b1;
                    busy_next   = 1'b1;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // The write on the bus this cycle is dropped, not accepted
                    state_next = ST_IDLE;
                    addr_next  = '0;
                    data_next  = '0;
                    wr_en_next = 1'b0;
                    sel_next   = 1'b0;
                    busy_next  = 1'b0;
                end else if (accept) begin
                    if (last_write) begin
                        state_next = ST_DONE;
                        wr_en_next = 1'b0;
                        sel_next   = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        // Address wraps naturally at 2**ADDR_W
                        addr_next   = addr_inc;
                        offset_next = offset_inc;
                        data_next   = pat_data;
                    end
                end
                // While stalled everything on the bus simply holds
            end

            ST_DONE: begin
                // done is high for this single cycle only
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                addr_next  = '0;
                data_next  = '0;
                wr_en_next = 1'b0;
                sel_next   = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            mode_reg   <= '0;
            fill_reg   <= '0;
            end_reg    <= '0;
            offset_reg <= '0;
            addr_reg   <= '0;
            data_reg   <= '0;
            wr_en_reg  <= 1'b0;
            sel_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mode_reg   <= mode_next;
            fill_reg   <= fill_next;
            end_reg    <= end_next;
            offset_reg <= offset_next;
            addr_reg   <= addr_next;
            data_reg   <= data_next;
            wr_en_reg  <= wr_en_next;
            sel_reg    <= sel_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign wr_data = data_reg;
    assign wr_addr = addr_reg;
    assign wr_en   = wr_en_reg;
    assign sel_out = sel_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule
